mp_add_seq: RTL

- Multi-precision add sequencer that time-multiplexes one 32-bit carry-increment adder (Carryincadder) to add WORDS×32-bit operands.
- Operands stream in least significant word first; each word's carry-out is registered and fed back as the next word's carry-in.
- Sits between the operand-fetch logic and the result writeback, with valid/ready handshakes on both sides.

---
 rtl/mp_add_pkg.sv | 12 +
 rtl/mp_add_seq_carryincadder.sv | 36 +++
 rtl/mp_add_seq.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mp_add_pkg.sv
// Shared types and constants for the multi-precision add sequencer.
// One adder datapath word is WORD_W bits wide; WORDS_DEF is the default operand length in words.
package mp_add_pkg;
   localparam int WORD_W    = 32;
   localparam int WORDS_DEF = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;
endpackage

// File: rtl/mp_add_seq_carryincadder.sv
// Combinational 32-bit carry-increment adder: 8-bit blocks add with carry-in 0 and are then
// incremented when the rippled block carry is set. Zero latency, no handshake.
module Carryincadder
   import mp_add_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   input  logic              c0,
   output logic [WORD_W-1:0] sum,
   output logic              cout,
   output logic              of
);
   localparam int BLK  = 8;
   localparam int NBLK = WORD_W / BLK;

   logic [NBLK:0]  c;
   logic [BLK:0]   s0;
   logic [BLK-1:0] s1;

   always_comb begin
      c    = '0;
      c[0] = c0;
      sum  = '0;
      s0   = '0;
      s1   = '0;
      for (int i = 0; i < NBLK; i++) begin
         s0 = {1'b0, a[i*BLK +: BLK]} + {1'b0, b[i*BLK +: BLK]};
         s1 = s0[BLK-1:0] + {{(BLK-1){1'b0}}, c[i]};
         sum[i*BLK +: BLK] = s1;
         // Block propagates the incoming carry only when its zero-carry sum is all ones.
         c[i+1] = s0[BLK] | (c[i] & (&s0[BLK-1:0]));
      end
      cout = c[NBLK];
      of   = (a[WORD_W-1] == b[WORD_W-1]) && (sum[WORD_W-1] != a[WORD_W-1]);
   end
endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add sequencer: WORDS x 32-bit words through one adder, LS word first, 1-cycle
// accept-to-output latency, single output register stalls input when full; MP_ADD_SEQ_SUB_EN adds subtract.
module mp_add_seq
   import mp_add_pkg::*;
#(
   parameter int WORDS = WORDS_DEF,
   parameter int CNT_W = $clog2(WORDS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
`ifdef MP_ADD_SEQ_SUB_EN
   input  logic              sub,
`endif
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] a_word,
   input  logic [WORD_W-1:0] b_word,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] sum_word,
   output logic              out_last,
   output logic              cout,
   output logic              of,
   output logic              busy,
   output logic              done
);
   state_t            state, state_next;
   logic [CNT_W-1:0]  cnt;
   logic              carry_reg;
   logic [WORD_W-1:0] b_eff, add_sum;
   logic              add_cout, add_of;
   logic              accept, last_word, carry_init;

`ifdef MP_ADD_SEQ_SUB_EN
   logic sub_q;
   assign b_eff      = sub_q ? ~b_word : b_word;
   assign carry_init = sub;
`else
   assign b_eff      = b_word;
   assign carry_init = 1'b0;
`endif

   assign last_word = (cnt == CNT_W'(WORDS - 1));
   assign accept    = in_valid && in_ready;

   Carryincadder u_adder (
      .a    (a_word),
      .b    (b_eff),
      .c0   (carry_reg),
      .sum  (add_sum),
      .cout (add_cout),
      .of   (add_of)
   );

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE: if (start) state_next = RUN;
         RUN: begin
            in_ready = !out_valid || out_ready;
            if (in_valid && in_ready && last_word) state_next = DRAIN;
         end
         DRAIN: if (out_valid && out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         carry_reg <= 1'b0;
         out_valid <= 1'b0;
         sum_word  <= '0;
         out_last  <= 1'b0;
         cout      <= 1'b0;
         of        <= 1'b0;
         done      <= 1'b0;
`ifdef MP_ADD_SEQ_SUB_EN
         sub_q     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               cnt       <= '0;
               carry_reg <= carry_init;
               cout      <= 1'b0;
               of        <= 1'b0;
`ifdef MP_ADD_SEQ_SUB_EN
               sub_q     <= sub;
`endif
            end
            RUN: begin
               if (accept) begin
                  sum_word  <= add_sum;
                  carry_reg <= add_cout;
                  out_valid <= 1'b1;
                  if (last_word) begin
                     out_last <= 1'b1;
                     cout     <= add_cout;
                     of       <= add_of;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end else if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            DRAIN: if (out_valid && out_ready) begin
               out_valid <= 1'b0;
               out_last  <= 1'b0;
               done      <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule
